victim_cache_assoc: RTL and testbench

Parametrised, fully associative victim cache between the L1 data cache and L2/physical memory. It holds up to ENTRIES lines evicted from L1, tracked with true LRU replacement. It returns a line to L1 on a lookup hit, invalidating its copy, and forwards lookup misses to L2. When a dirty LRU line must be displaced, it writes that line back to L2. Hit/miss counters are exposed for performance analysis.

---
 rtl/victim_cache_assoc.sv | 192 +++++++++++++++++++
 tb/tb_victim_cache_assoc.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/victim_cache_assoc.sv
// Fully associative victim cache between L1 and L2 with true-LRU replacement,
// dirty write-back on eviction, and saturating hit/miss statistics.
module victim_cache_assoc #(
  parameter int ENTRIES  = 4,
  parameter int TAG_W    = 12,
  parameter int OFFSET_W = 4,
  parameter int LINE_W   = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                l1_read,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic                l1_write,
  input  logic [TAG_W-1:0]    l1_tag,
  input  logic [LINE_W-1:0]   l1_wdata,
  input  logic                dirty_in,
  output logic [LINE_W-1:0]   l1_rdata,
  output logic                l1_dirty,
  output logic                mem_resp,
  input  logic [LINE_W-1:0]   l2_rdata,
  input  logic                l2_mem_resp,
  output logic [15:0]         l2_address,
  output logic [LINE_W-1:0]   l2_wdata,
  output logic                l2_read,
  output logic                l2_write,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
);

  localparam int AW = $clog2(ENTRIES);
  localparam logic [AW-1:0] LRU_AGE  = AW'(ENTRIES - 1);
  // An entry being installed from the invalid pool ranks older than every valid entry.
  localparam logic [AW:0]   FREE_AGE = (AW + 1)'(ENTRIES);

  typedef enum logic [1:0] {IDLE, RESP, L2_RD, WB} state_t;

  state_t              state;
  logic [ENTRIES-1:0]  valid;
  logic [ENTRIES-1:0]  dirty;
  logic [AW-1:0]       age   [ENTRIES];
  logic [TAG_W-1:0]    tags  [ENTRIES];
  logic [LINE_W-1:0]   lines [ENTRIES];
  logic [AW-1:0]       victim;

  logic          rd_hit, wr_hit, free;
  logic [AW-1:0] rd_idx, wr_idx, free_idx, lru_idx;
  logic          ins_en, ins_merge;
  logic [AW-1:0] ins_idx;
  logic [AW:0]   ins_old;

  // NOTE: every always_comb output gets a default first, otherwise a path that
  // skips an assignment infers a latch.
  always_comb begin
    rd_hit   = 1'b0;
    rd_idx   = '0;
    wr_hit   = 1'b0;
    wr_idx   = '0;
    free     = 1'b0;
    free_idx = '0;
    lru_idx  = '0;
    // Descending scan so the lowest-index invalid entry is the one kept.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = AW'(i);
      end
      if (valid[i] && tags[i] == req_tag) begin
        rd_hit = 1'b1;
        rd_idx = AW'(i);
      end
      if (valid[i] && tags[i] == l1_tag) begin
        wr_hit = 1'b1;
        wr_idx = AW'(i);
      end
      if (valid[i] && age[i] == LRU_AGE) lru_idx = AW'(i);
    end
  end

  always_comb begin
    ins_en    = 1'b0;
    ins_merge = 1'b0;
    ins_idx   = lru_idx;
    if (state == IDLE && l1_write) begin
      if (wr_hit) begin
        ins_en    = 1'b1;
        ins_merge = 1'b1;
        ins_idx   = wr_idx;
      end else if (free) begin
        ins_en  = 1'b1;
        ins_idx = free_idx;
      end else if (!dirty[lru_idx]) begin
        ins_en = 1'b1;
      end
    end else if (state == WB && l2_mem_resp) begin
      ins_en  = 1'b1;
      ins_idx = victim;
    end
    ins_old = valid[ins_idx] ? {1'b0, age[ins_idx]} : FREE_AGE;
  end

  // NOTE: the tag/data arrays carry no reset; the valid bits alone decide
  // whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (ins_en) begin
      tags[ins_idx]  <= l1_tag;
      lines[ins_idx] <= l1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      for (int i = 0; i < ENTRIES; i++) age[i] <= '0;
      victim     <= '0;
      mem_resp   <= 1'b0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
      l1_rdata   <= '0;
      l1_dirty   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ins_en) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (AW'(i) == ins_idx) age[i] <= '0;
          else if (valid[i] && {1'b0, age[i]} < ins_old) age[i] <= age[i] + 1'b1;
        end
        valid[ins_idx] <= 1'b1;
        dirty[ins_idx] <= dirty_in | (ins_merge & dirty[ins_idx]);
      end

      case (state)
        IDLE: begin
          if (l1_write) begin
            if (ins_en) begin
              mem_resp <= 1'b1;
              state    <= RESP;
            end else begin
              victim     <= lru_idx;
              l2_address <= {tags[lru_idx], {OFFSET_W{1'b0}}};
              l2_wdata   <= lines[lru_idx];
              l2_write   <= 1'b1;
              state      <= WB;
            end
          end else if (l1_read) begin
            if (rd_hit) begin
              l1_rdata       <= lines[rd_idx];
              l1_dirty       <= dirty[rd_idx];
              valid[rd_idx]  <= 1'b0;
              for (int i = 0; i < ENTRIES; i++)
                if (valid[i] && age[i] > age[rd_idx]) age[i] <= age[i] - 1'b1;
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
              mem_resp <= 1'b1;
              state    <= RESP;
            end else begin
              l2_address <= {req_tag, {OFFSET_W{1'b0}}};
              l2_read    <= 1'b1;
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
              state      <= L2_RD;
            end
          end
        end
        L2_RD: begin
          if (l2_mem_resp) begin
            l2_read  <= 1'b0;
            l1_rdata <= l2_rdata;
            l1_dirty <= 1'b0;
            mem_resp <= 1'b1;
            state    <= RESP;
          end
        end
        WB: begin
          if (l2_mem_resp) begin
            l2_write <= 1'b0;
            mem_resp <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          mem_resp <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache_assoc.sv
// Randomized bench for victim_cache_assoc against a queue-ordered LRU model
// (front of queue = MRU) with an inline L2 responder of variable latency.
module tb_victim_cache_assoc;
  localparam int ENTRIES = 4, TAG_W = 12, OFFSET_W = 4, LINE_W = 128;

  logic clk = 1'b0, rst_n = 1'b0;
  logic l1_read = 1'b0, l1_write = 1'b0, dirty_in = 1'b0, l2_mem_resp = 1'b0;
  logic [TAG_W-1:0]  req_tag = '0, l1_tag = '0;
  logic [LINE_W-1:0] l1_wdata = '0, l2_rdata = '0;
  logic [LINE_W-1:0] l1_rdata, l2_wdata;
  logic              l1_dirty, mem_resp, l2_read, l2_write;
  logic [15:0]       l2_address, hit_count, miss_count;

  always #5 clk = ~clk;

  victim_cache_assoc #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n), .l1_read(l1_read), .req_tag(req_tag), .l1_write(l1_write),
    .l1_tag(l1_tag), .l1_wdata(l1_wdata), .dirty_in(dirty_in), .l1_rdata(l1_rdata),
    .l1_dirty(l1_dirty), .mem_resp(mem_resp), .l2_rdata(l2_rdata), .l2_mem_resp(l2_mem_resp),
    .l2_address(l2_address), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
    .hit_count(hit_count), .miss_count(miss_count));

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
    logic              dirty;
  } line_t;

  line_t       model_q[$];
  int unsigned exp_hits = 0, exp_misses = 0;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int find_tag(input logic [TAG_W-1:0] t);
    for (int i = 0; i < model_q.size(); i++) if (model_q[i].tag == t) return i;
    return -1;
  endfunction

  task automatic apply_reset();
    l1_read = 1'b0; l1_write = 1'b0; l2_mem_resp = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_q.delete();
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Step past the RESP cycle; the cache must be quiet again in IDLE.
  task automatic finish_op();
    @(negedge clk);
    n_checks++;
    if (mem_resp !== 1'b0 || l2_read !== 1'b0 || l2_write !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_resp: mem_resp=%b l2_read=%b l2_write=%b, expected all 0",
               mem_resp, l2_read, l2_write);
    end
  endtask

  task automatic do_insert(input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] d,
                           input logic dty, input int lat);
    int    idx = find_tag(t);
    logic  exp_wb = 1'b0;
    line_t vic = '0;
    line_t nl;
    nl = '{t, d, dty};
    if (idx >= 0) begin
      nl.dirty = dty | model_q[idx].dirty;
      model_q.delete(idx);
    end else if (model_q.size() == ENTRIES) begin
      vic    = model_q.pop_back();
      exp_wb = vic.dirty;
    end
    model_q.push_front(nl);

    l1_write = 1'b1; l1_tag = t; l1_wdata = d; dirty_in = dty;
    @(negedge clk);
    if (exp_wb) begin
      n_checks++;
      if (l2_write !== 1'b1 || l2_read !== 1'b0 || mem_resp !== 1'b0 ||
          l2_address !== {vic.tag, 4'h0} || l2_wdata !== vic.data) begin
        n_fail++;
        $display("FAIL ins_wb_req tag=%h: l2_write=%b l2_read=%b mem_resp=%b addr=%h wdata=%h, expected 1 0 0 addr=%h wdata=%h",
                 t, l2_write, l2_read, mem_resp, l2_address, l2_wdata, {vic.tag, 4'h0}, vic.data);
      end
      repeat (lat) begin
        @(negedge clk);
        n_checks++;
        if (l2_write !== 1'b1 || l2_address !== {vic.tag, 4'h0} || l2_wdata !== vic.data || mem_resp !== 1'b0) begin
          n_fail++;
          $display("FAIL ins_wb_hold: l2_write=%b addr=%h mem_resp=%b, expected 1 addr=%h 0",
                   l2_write, l2_address, mem_resp, {vic.tag, 4'h0});
        end
      end
      l2_mem_resp = 1'b1;
      @(negedge clk);
      l2_mem_resp = 1'b0;
    end else begin
      n_checks++;
      if (l2_write !== 1'b0 || l2_read !== 1'b0) begin
        n_fail++;
        $display("FAIL ins_no_l2 tag=%h: l2_write=%b l2_read=%b, expected 0 0", t, l2_write, l2_read);
      end
    end
    n_checks++;
    if (mem_resp !== 1'b1 || l2_write !== 1'b0) begin
      n_fail++;
      $display("FAIL ins_resp tag=%h: mem_resp=%b l2_write=%b, expected 1 0", t, mem_resp, l2_write);
    end
    l1_write = 1'b0;
    finish_op();
  endtask

  task automatic do_read(input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] l2d, input int lat);
    int    idx = find_tag(t);
    line_t hl;
    if (idx >= 0) begin
      hl = model_q[idx];
      model_q.delete(idx);
      if (exp_hits < 65535) exp_hits++;
    end else begin
      hl = '{t, l2d, 1'b0};
      if (exp_misses < 65535) exp_misses++;
    end

    l1_read = 1'b1; req_tag = t;
    @(negedge clk);
    if (idx < 0) begin
      n_checks++;
      if (l2_read !== 1'b1 || l2_write !== 1'b0 || mem_resp !== 1'b0 || l2_address !== {t, 4'h0}) begin
        n_fail++;
        $display("FAIL rd_miss_req tag=%h: l2_read=%b l2_write=%b mem_resp=%b addr=%h, expected 1 0 0 addr=%h",
                 t, l2_read, l2_write, mem_resp, l2_address, {t, 4'h0});
      end
      repeat (lat) begin
        @(negedge clk);
        n_checks++;
        if (l2_read !== 1'b1 || l2_address !== {t, 4'h0} || mem_resp !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_miss_hold: l2_read=%b addr=%h mem_resp=%b, expected 1 addr=%h 0",
                   l2_read, l2_address, mem_resp, {t, 4'h0});
        end
      end
      l2_rdata = l2d; l2_mem_resp = 1'b1;
      @(negedge clk);
      l2_mem_resp = 1'b0; l2_rdata = rand_line();
    end else begin
      n_checks++;
      if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_hit_no_l2 tag=%h: l2_read=%b l2_write=%b, expected 0 0", t, l2_read, l2_write);
      end
    end
    n_checks++;
    if (mem_resp !== 1'b1 || l2_read !== 1'b0 || l1_rdata !== hl.data || l1_dirty !== hl.dirty) begin
      n_fail++;
      $display("FAIL rd_data tag=%h: mem_resp=%b l2_read=%b data=%h dirty=%b, expected 1 0 data=%h dirty=%b",
               t, mem_resp, l2_read, l1_rdata, l1_dirty, hl.data, hl.dirty);
    end
    n_checks++;
    if (hit_count !== 16'(exp_hits) || miss_count !== 16'(exp_misses)) begin
      n_fail++;
      $display("FAIL rd_counts tag=%h: hits=%0d misses=%0d, expected %0d %0d",
               t, hit_count, miss_count, exp_hits, exp_misses);
    end
    l1_read = 1'b0;
    finish_op();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (mem_resp !== 1'b0 || l2_read !== 1'b0 || l2_write !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: mem_resp=%b l2_read=%b l2_write=%b hits=%0d misses=%0d, expected all 0",
               mem_resp, l2_read, l2_write, hit_count, miss_count);
    end
    n_checks++;
    if (l1_rdata !== '0 || l1_dirty !== 1'b0 || l2_address !== 16'h0 || l2_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: l1_rdata=%h l1_dirty=%b l2_address=%h l2_wdata=%h, expected all 0",
               l1_rdata, l1_dirty, l2_address, l2_wdata);
    end
  endtask

  task automatic test_miss();
    apply_reset();
    do_read(12'h123, {16{8'hA5}}, 2);
    do_read(12'h123, rand_line(), 0);  // no allocation on a miss
  endtask

  task automatic test_hit();
    apply_reset();
    do_insert(12'h010, rand_line(), 1'b1, 0);
    do_read(12'h010, rand_line(), 0);
    do_read(12'h010, rand_line(), 1);
  endtask

  task automatic test_clean_evict();
    apply_reset();
    for (int t = 1; t <= 5; t++) do_insert(TAG_W'(t), rand_line(), 1'b0, 0);
    do_read(12'h001, rand_line(), 1);
    do_read(12'h002, rand_line(), 0);
  endtask

  task automatic test_dirty_evict();
    apply_reset();
    for (int t = 1; t <= 4; t++) do_insert(TAG_W'(t), rand_line(), 1'b1, 0);
    do_insert(12'h005, rand_line(), 1'b0, 2);
    do_read(12'h005, rand_line(), 0);
    do_read(12'h001, rand_line(), 0);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req_tag = 12'h0AB;
    l1_read = 1'b1;
    do_insert(12'h0AB, rand_line(), 1'b0, 0);
    do_read(12'h0AB, rand_line(), 0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      logic [TAG_W-1:0] t = TAG_W'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_insert(t, rand_line(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      else
        do_read(t, rand_line(), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_wb();
    apply_reset();
    for (int t = 1; t <= 4; t++) do_insert(TAG_W'(t), rand_line(), 1'b1, 0);
    do_read(12'h077, rand_line(), 0);
    l1_write = 1'b1; l1_tag = 12'h005; l1_wdata = rand_line(); dirty_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (l2_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_wb_start: l2_write=%b, expected 1", l2_write);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (l2_write !== 1'b0 || l2_read !== 1'b0 || mem_resp !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_wb_async: l2_write=%b l2_read=%b mem_resp=%b hits=%0d misses=%0d, expected all 0",
               l2_write, l2_read, mem_resp, hit_count, miss_count);
    end
    l1_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_q.delete();
    exp_hits = 0;
    exp_misses = 0;
    do_read(12'h001, rand_line(), 0);
    do_read(12'h005, rand_line(), 1);
  endtask

  // Enough back-to-back insert+hit pairs to push hit_count past its 16-bit ceiling.
  task automatic test_saturation();
    localparam int N = 65540;
    logic [LINE_W-1:0] d = rand_line();
    apply_reset();
    l1_tag = 12'h3C3; req_tag = 12'h3C3; l1_wdata = d; dirty_in = 1'b0;
    l1_read = 1'b1;
    for (int i = 0; i < N; i++) begin
      l1_write = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mem_resp !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_insert iter=%0d: mem_resp=%b, expected 1", i, mem_resp);
      end
      l1_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (mem_resp !== 1'b1 || l1_rdata !== d || l2_read !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_hit iter=%0d: mem_resp=%b l2_read=%b data=%h, expected 1 0 data=%h",
                 i, mem_resp, l2_read, l1_rdata, d);
      end
      @(negedge clk);
    end
    l1_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hit_count !== 16'hFFFF || miss_count !== 16'd0) begin
      n_fail++;
      $display("FAIL sat_count: hits=%h misses=%h, expected ffff 0000", hit_count, miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_clean_evict();
    test_dirty_evict();
    test_simultaneous();
    test_random();
    test_reset_mid_wb();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
